// File: rtl/cam_rgb565_capture.sv
// cam_rgb565_capture
//   Deserialises a vsync/href framed RGB565 byte stream into 8-bit R/G/B
//   pixels with a one-cycle done_o strobe, pixel coordinates, frame
//   start/done pulses and a sticky format-error flag.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     cam_vsync_i              frame sync (high during vertical blanking)
//     cam_href_i               line valid (high during active bytes)
//     cam_byte_en_i            one-cycle strobe, cam_data_i valid
//     cam_data_i[7:0]          camera byte
//     red_o/green_o/blue_o     expanded 8-bit colour of the last pixel
//     done_o                   one-cycle pixel valid
//     x_o[XW-1:0], y_o[YW-1:0] coordinates of the pixel on the colour outputs
//     frame_start_o            pulse on vsync falling edge
//     frame_done_o             pulse on vsync rising edge after an active frame
//     err_o                    sticky format error, cleared at frame start
//
//   Build option: CAM_BYTE_SWAP_EN - when defined the first byte of each pair
//   is the low byte and the second the high byte.

module cam_rgb565_capture #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_vsync_i,
    input  logic          cam_href_i,
    input  logic          cam_byte_en_i,
    input  logic [7:0]    cam_data_i,
    output logic [7:0]    red_o,
    output logic [7:0]    green_o,
    output logic [7:0]    blue_o,
    output logic          done_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          frame_start_o,
    output logic          frame_done_o,
    output logic          err_o
);

    localparam logic [XW-1:0] X_END = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_END = YW'(IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_VBLANK  = 2'd1,
        S_ACTIVE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          phase_q, phase_d;
    logic [7:0]    hold_q, hold_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic [7:0]    blue_q, blue_d;
    logic          done_q, done_d;
    logic [XW-1:0] x_out_q, x_out_d;
    logic [YW-1:0] y_out_q, y_out_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    // Pixel assembly from the held byte and the current byte
    logic [7:0] pix_hi;
    logic [7:0] pix_lo;
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

`ifdef CAM_BYTE_SWAP_EN
    assign pix_hi = cam_data_i;
    assign pix_lo = hold_q;
`else
    assign pix_hi = hold_q;
    assign pix_lo = cam_data_i;
`endif

    assign r5 = pix_hi[7:3];
    assign g6 = {pix_hi[2:0], pix_lo[7:5]};
    assign b5 = pix_lo[4:0];

    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;
    logic byte_ok;

    assign vsync_rise = ~vsync_q & cam_vsync_i;
    assign vsync_fall = vsync_q & ~cam_vsync_i;
    assign href_fall  = href_q & ~cam_href_i;
    assign byte_ok    = cam_href_i & cam_byte_en_i;

    // Next-state and output computation
    always_comb begin
        state_d       = state_q;
        vsync_d       = cam_vsync_i;
        href_d        = cam_href_i;
        phase_d       = phase_q;
        hold_d        = hold_q;
        x_d           = x_q;
        y_d           = y_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        done_d        = 1'b0;
        x_out_d       = x_out_q;
        y_out_d       = y_out_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = err_q;

        case (state_q)
            // Wait for blanking so a partial frame after reset is never captured
            S_SYNC: begin
                if (cam_vsync_i) begin
                    state_d = S_VBLANK;
                end
            end

            S_VBLANK: begin
                if (vsync_fall) begin
                    state_d       = S_ACTIVE;
                    frame_start_d = 1'b1;
                    err_d         = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                    phase_d       = 1'b0;
                end
            end

            S_ACTIVE: begin
                if (vsync_rise) begin
                    // End of frame wins over any byte on this cycle
                    state_d      = S_VBLANK;
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    if ((y_q != Y_END) || cam_href_i) begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (byte_ok) begin
                        if (!phase_q) begin
                            hold_d  = cam_data_i;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if ((x_q < X_END) && (y_q < Y_END)) begin
                                done_d  = 1'b1;
                                red_d   = {r5, r5[4:2]};
                                green_d = {g6, g6[5:4]};
                                blue_d  = {b5, b5[4:2]};
                                x_out_d = x_q;
                                y_out_d = y_q;
                                x_d     = x_q + XW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    // Line end rules see the result of any capture above
                    if (href_fall) begin
                        if (phase_d || (x_d != X_END)) begin
                            err_d = 1'b1;
                        end
                        phase_d = 1'b0;
                        x_d     = '0;
                        if (y_q != Y_END) begin
                            y_d = y_q + YW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_SYNC;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hold_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            done_q        <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            x_q           <= x_d;
            y_q           <= y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            done_q        <= done_d;
            x_out_q       <= x_out_d;
            y_out_q       <= y_out_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign done_o        = done_q;
    assign x_o           = x_out_q;
    assign y_o           = y_out_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;

endmodule

// File: doc/cam_rgb565_capture.md
Name: cam_rgb565_capture

Overview:
Camera-side producer of the RGB pixel interface used by the grayscale stage. It deserialises an RGB565 byte stream framed by vsync/href into 8-bit R, G and B values, each with a one-cycle done_o strobe. It also tracks pixel and line position and flags malformed frames. It sits between the camera pin interface (already synchronised to clk, one byte per cam_byte_en_i) and the RGB-to-grayscale converter.

Parameters:
IMG_WIDTH, 640, pixels per active line
IMG_HEIGHT, 480, active lines per frame
XW, 10, width of x_o counter (must hold IMG_WIDTH)
YW, 9, width of y_o counter (must hold IMG_HEIGHT)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cam_vsync_i  input  1  frame sync, high during vertical blanking
cam_href_i  input  1  line valid, high during active bytes
cam_byte_en_i  input  1  one-cycle strobe, cam_data_i valid this cycle
cam_data_i  input  8  camera byte
red_o  output  8  expanded red
green_o  output  8  expanded green
blue_o  output  8  expanded blue
done_o  output  1  pixel valid, one cycle per pixel
x_o  output  XW  column of pixel on red/green/blue_o
y_o  output  YW  row of pixel on red/green/blue_o
frame_start_o  output  1  one-cycle pulse on vsync falling edge
frame_done_o  output  1  one-cycle pulse on vsync rising edge after an active frame
err_o  output  1  sticky format error, cleared on next frame_start_o

Behaviour:
- Reset (async, any time, including mid-frame): all outputs 0, FSM to S_SYNC, byte phase 0, counters 0, held high byte 0.
- FSM states:
  - S_SYNC: ignore all input until cam_vsync_i=1, then go to S_VBLANK. This prevents capture of a partial frame after reset.
  - S_VBLANK: on cam_vsync_i 1->0, pulse frame_start_o, clear err_o, x=0, y=0, phase=0, go to S_ACTIVE.
  - S_ACTIVE: capture bytes. On cam_vsync_i 0->1, pulse frame_done_o and go to S_VBLANK.
- Byte capture applies only in S_ACTIVE with cam_href_i=1 and cam_byte_en_i=1.
  - Phase 0: latch the byte as hi and set phase to 1.
  - Phase 1: the byte is lo. Form pixel {hi,lo} and set phase to 0.
- Pixel fields: r5={hi[7:3]}, g6={hi[2:0],lo[7:5]}, b5=lo[4:0].
- Expansion by bit replication: red_o={r5,r5[4:2]}, green_o={g6,g6[5:4]}, blue_o={b5,b5[4:2]}.
- Output latency: red/green/blue_o, x_o, y_o and done_o are registered and valid the cycle after the low-byte strobe.
- done_o is high for exactly 1 cycle per pixel. Colour, x and y outputs hold their values until the next pixel.
- Counters: after each accepted pixel x increments. done_o asserts only while x<IMG_WIDTH and y<IMG_HEIGHT.
  - Excess pixels in a line are dropped and set err_o.
  - Excess lines are dropped and set err_o.
- href falling (1->0) in S_ACTIVE:
  - If phase=1, discard the dangling byte, set phase=0 and set err_o.
  - If x!=IMG_WIDTH, set err_o.
  - Then x=0, y=y+1 (saturating at IMG_HEIGHT).
- vsync rising in S_ACTIVE:
  - Set err_o if y!=IMG_HEIGHT or href is still high.
  - Any pending phase is discarded.
- Simultaneous events:
  - A byte strobe on the same cycle as href falling is captured first, then the line-end rules apply.
  - vsync rising takes priority over a byte strobe; that byte is ignored.
- cam_byte_en_i outside S_ACTIVE or with href=0 is ignored.

Optional Feature:
CAM_BYTE_SWAP_EN
- Defined: the first byte of each pair is the low byte (lo) and the second is the high byte (hi). The pixel is still formed as {hi,lo}.
- Undefined: the first byte is hi, as described above.
- The macro changes no ports and no latency.

Test Plan:
- Bench configuration for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=2.
- Reset, then href bytes with vsync=0 (no prior vsync high) -> no done_o. After vsync high then low -> frame_start_o is one pulse.
- Line of pairs F8 00, 07 E0, 00 1F, 84 10 -> four done_o pulses:
  - (FF,00,00) x0
  - (00,FF,00) x1
  - (00,00,FF) x2
  - (84,82,84) x3
  - all with y0 and err_o=0.
- Full frame of 2 lines x 4 pixels, then vsync rising -> 8 done_o pulses, y_o 0 then 1, one frame_done_o, err_o=0.
- Line with 5 pixels -> 4 done_o pulses, 5th dropped, err_o=1. err_o stays 1 through frame_done_o and clears at the next frame_start_o.
- Line with 7 bytes (href falls at phase 1) -> 3 done_o pulses, err_o=1, next line starts at x0 with correct pairing.
- Assert rst mid-line after a high byte -> outputs 0 immediately (async). After release, nothing is captured until a vsync high->low sequence; the first pixel then decodes correctly.
- With CAM_BYTE_SWAP_EN defined, bytes 00 F8 -> done_o with (FF,00,00).
